tlb_pipe: RTL and testbench
===========================

TLB_PIPE -- requirements
Module: tlb_pipe

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, entry count; power of two, 4..64.
REQ-002 SHALL have derived parameter IDXW, default $clog2(TLBNUM), index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports sN_vppn / sN_va_bit12 / sN_asid, N=0,1  input  19/1/10  search keys (port 0 fetch, port 1 load/store).
REQ-006 SHALL have ports sN_found / sN_index / sN_ppn / sN_ps / sN_plv / sN_mat / sN_d / sN_v  output  1/IDXW/20/6/2/2/1/1  registered search result.
REQ-007 SHALL have ports inv_valid / inv_op / inv_asid / inv_vppn  input  1/5/10/19  INVTLB request.
REQ-008 SHALL have ports inv_busy / inv_done / inv_err  output  1/1/1  INVTLB status.
REQ-009 SHALL have ports we / w_index  input  1/IDXW  write strobe and target.
REQ-010 SHALL have ports w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0/1, w_plv0/1, w_mat0/1, w_d0/1, w_v0/1  input  1/19/6/10/1/20/2/2/1/1  entry fields.
REQ-011 SHALL have port fill_index  output  IDXW  index to use for TLBFILL.
REQ-012 SHALL have port fill_ack  input  1  pulsed with we when the write is a TLBFILL.
REQ-013 SHALL have port r_index  input  IDXW, and ports r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  output, widths as w_*; combinational TLBRD.

Function
REQ-014 Entry match SHALL be: e, vppn[18:10] equal, (4MB or vppn[9:0] equal), (asid equal or g).
REQ-015 Page size SHALL be stored as 1 bit: w_ps==22 -> 4MB, any other value -> 4KB; sN_ps and r_ps SHALL report 22 or 12.
REQ-016 Odd-page select SHALL be vppn[9] for 4MB entries, va_bit12 for 4KB entries.
REQ-017 Multiple hits SHALL resolve to the lowest matching index (priority encoder), never an OR of indices.
REQ-018 Search latency SHALL be exactly 1 cycle: keys sampled at edge k, results valid after edge k, held until next edge.
REQ-019 On miss, sN_found=0 and all other sN_* outputs SHALL be 0.
REQ-020 Search SHALL see entry state as of edge k (a write at edge k is not visible until the search sampled at edge k+1).
REQ-021 Write SHALL update all fields of entry w_index at the edge where we=1, also while inv_busy=1.
REQ-022 fill_index SHALL increment by 1 (mod TLBNUM) at each edge with we&fill_ack, wrapping TLBNUM-1 -> 0; otherwise hold.
REQ-023 INVTLB FSM SHALL have states IDLE, SCAN; inv_busy=1 exactly in SCAN.
REQ-024 IDLE with inv_valid=1 SHALL latch op/asid/vppn; legal op (0..6) -> SCAN with scan pointer 0; illegal op -> stay IDLE, pulse inv_done and inv_err for 1 cycle next cycle, no entry change.
REQ-025 inv_valid SHALL be ignored while inv_busy=1.
REQ-026 SCAN SHALL evaluate one entry per cycle, pointer 0..TLBNUM-1, clearing e when: op0/1 all; op2 g=1; op3 g=0; op4 g=0&asid; op5 g=0&asid&vppn; op6 (g or asid)&vppn; vppn compare is full 19 bits.
REQ-027 After the pointer=TLBNUM-1 cycle, FSM SHALL return to IDLE and pulse inv_done for 1 cycle; total TLBNUM cycles busy.
REQ-028 If we targets the entry being cleared in the same cycle, the write SHALL win.
REQ-029 TLBRD outputs SHALL be combinational from current state of r_index.

Reset
REQ-030 reset SHALL clear all e bits, fill_index=0, FSM=IDLE, scan pointer=0, all sN_* outputs, inv_busy, inv_done, inv_err to 0; other entry fields need not reset.
REQ-031 reset during SCAN SHALL abort without inv_done; reset has priority over we and inv_valid.

Verification
REQ-032 Write idx 3 {vppn=0x12345, asid=5, ps=12, ppn0=0xAAAAA, v0=1}; search s0 vppn=0x12345, bit12=0, asid=5 -> next cycle found=1, index=3, ppn=0xAAAAA, ps=12.
REQ-033 Write idx 2 and idx 9 both matching, ps=22, ppn1=0x11 / 0x22; search with vppn[9]=1 -> index=2, ppn=0x11, ps=22.
REQ-034 Three we&fill_ack pulses with TLBNUM=4 from fill_index=2 -> fill_index 3, 0, 1.
REQ-035 Entries g=1 at 0, g=0 asid=7 at 1, g=0 asid=8 at 2; inv op=4 asid=7 -> inv_busy 16 cycles, inv_done pulse, only entry 1 e=0.
REQ-036 inv op=9 -> inv_done and inv_err pulse 1 cycle later, inv_busy never 1, all entries unchanged.
REQ-037 op=0 scan, we to entry 5 on its scan cycle, then reset mid-scan -> entry 5 written e=1 before reset; after reset all e=0, no inv_done, fill_index=0.

Source files
------------

// File: rtl/tlb_pipe.sv
// Dual-port translation lookaside buffer: one-cycle registered lookups, combinational TLBRD,
// round-robin fill index and a one-entry-per-cycle INVTLB scanner.
module tlb_pipe #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [18:0]     s0_vppn,
  input  logic            s0_va_bit12,
  input  logic [9:0]      s0_asid,
  output logic            s0_found,
  output logic [IDXW-1:0] s0_index,
  output logic [19:0]     s0_ppn,
  output logic [5:0]      s0_ps,
  output logic [1:0]      s0_plv,
  output logic [1:0]      s0_mat,
  output logic            s0_d,
  output logic            s0_v,
  input  logic [18:0]     s1_vppn,
  input  logic            s1_va_bit12,
  input  logic [9:0]      s1_asid,
  output logic            s1_found,
  output logic [IDXW-1:0] s1_index,
  output logic [19:0]     s1_ppn,
  output logic [5:0]      s1_ps,
  output logic [1:0]      s1_plv,
  output logic [1:0]      s1_mat,
  output logic            s1_d,
  output logic            s1_v,
  input  logic            inv_valid,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  output logic            inv_busy,
  output logic            inv_done,
  output logic            inv_err,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  logic            w_e,
  input  logic [18:0]     w_vppn,
  input  logic [5:0]      w_ps,
  input  logic [9:0]      w_asid,
  input  logic            w_g,
  input  logic [19:0]     w_ppn0,
  input  logic [19:0]     w_ppn1,
  input  logic [1:0]      w_plv0,
  input  logic [1:0]      w_plv1,
  input  logic [1:0]      w_mat0,
  input  logic [1:0]      w_mat1,
  input  logic            w_d0,
  input  logic            w_d1,
  input  logic            w_v0,
  input  logic            w_v1,
  output logic [IDXW-1:0] fill_index,
  input  logic            fill_ack,
  input  logic [IDXW-1:0] r_index,
  output logic            r_e,
  output logic [18:0]     r_vppn,
  output logic [5:0]      r_ps,
  output logic [9:0]      r_asid,
  output logic            r_g,
  output logic [19:0]     r_ppn0,
  output logic [19:0]     r_ppn1,
  output logic [1:0]      r_plv0,
  output logic [1:0]      r_plv1,
  output logic [1:0]      r_mat0,
  output logic [1:0]      r_mat1,
  output logic            r_d0,
  output logic            r_d1,
  output logic            r_v0,
  output logic            r_v1
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} inv_state_t;

  logic [TLBNUM-1:0] e_r, g_r, ps4m_r, d0_r, d1_r, v0_r, v1_r;
  logic [18:0] vppn_r [TLBNUM];
  logic [9:0]  asid_r [TLBNUM];
  logic [19:0] ppn0_r [TLBNUM];
  logic [19:0] ppn1_r [TLBNUM];
  logic [1:0]  plv0_r [TLBNUM];
  logic [1:0]  plv1_r [TLBNUM];
  logic [1:0]  mat0_r [TLBNUM];
  logic [1:0]  mat1_r [TLBNUM];

  logic [18:0]     key_vppn_s [2];
  logic            key_b12_s  [2];
  logic [9:0]      key_asid_s [2];
  logic            hit_s      [2];
  logic [IDXW-1:0] hidx_s     [2];
  logic            odd_s      [2];

  logic            s_found_r [2];
  logic [IDXW-1:0] s_index_r [2];
  logic [19:0]     s_ppn_r   [2];
  logic [5:0]      s_ps_r    [2];
  logic [1:0]      s_plv_r   [2];
  logic [1:0]      s_mat_r   [2];
  logic            s_d_r     [2];
  logic            s_v_r     [2];

  inv_state_t      state_r, state_nxt_s;
  logic [IDXW-1:0] ptr_r, ptr_nxt_s, fill_r;
  logic [4:0]      inv_op_r;
  logic [9:0]      inv_asid_r;
  logic [18:0]     inv_vppn_r;
  logic            latch_s, clr_s, done_nxt_s, err_nxt_s, done_r, err_r;

  function automatic logic entry_match(input logic e, input logic g, input logic ps4m,
                                       input logic [18:0] ev, input logic [9:0] ea,
                                       input logic [18:0] kv, input logic [9:0] ka);
    return e && (ev[18:10] == kv[18:10]) && (ps4m || (ev[9:0] == kv[9:0])) && (g || (ea == ka));
  endfunction

  function automatic logic inv_hit(input logic [4:0] op, input logic g, input logic [9:0] ea,
                                   input logic [18:0] ev, input logic [9:0] ka, input logic [18:0] kv);
    logic asid_eq, vppn_eq;
    asid_eq = (ea == ka);
    vppn_eq = (ev == kv);
    case (op)
      5'd0, 5'd1: inv_hit = 1'b1;
      5'd2:       inv_hit = g;
      5'd3:       inv_hit = !g;
      5'd4:       inv_hit = !g && asid_eq;
      5'd5:       inv_hit = !g && asid_eq && vppn_eq;
      5'd6:       inv_hit = (g || asid_eq) && vppn_eq;
      default:    inv_hit = 1'b0;
    endcase
  endfunction

  assign key_vppn_s[0] = s0_vppn;  assign key_b12_s[0] = s0_va_bit12;  assign key_asid_s[0] = s0_asid;
  assign key_vppn_s[1] = s1_vppn;  assign key_b12_s[1] = s1_va_bit12;  assign key_asid_s[1] = s1_asid;

  // Priority encode: scanning downward lets the lowest matching index overwrite the others.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      hit_s[p]  = 1'b0;
      hidx_s[p] = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (entry_match(e_r[i], g_r[i], ps4m_r[i], vppn_r[i], asid_r[i], key_vppn_s[p], key_asid_s[p])) begin
          hit_s[p]  = 1'b1;
          hidx_s[p] = IDXW'(i);
        end else begin
          hit_s[p]  = hit_s[p];
        end
      end
      odd_s[p] = ps4m_r[hidx_s[p]] ? key_vppn_s[p][9] : key_b12_s[p];
    end
  end

  // Search result registers; a miss forces every field to zero.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset || !hit_s[p]) begin
        s_found_r[p] <= 1'b0;          s_index_r[p] <= '0;
        s_ppn_r[p]   <= 20'd0;         s_ps_r[p]    <= 6'd0;
        s_plv_r[p]   <= 2'd0;          s_mat_r[p]   <= 2'd0;
        s_d_r[p]     <= 1'b0;          s_v_r[p]     <= 1'b0;
      end else begin
        s_found_r[p] <= 1'b1;
        s_index_r[p] <= hidx_s[p];
        s_ps_r[p]    <= ps4m_r[hidx_s[p]] ? 6'd22 : 6'd12;
        s_ppn_r[p]   <= odd_s[p] ? ppn1_r[hidx_s[p]] : ppn0_r[hidx_s[p]];
        s_plv_r[p]   <= odd_s[p] ? plv1_r[hidx_s[p]] : plv0_r[hidx_s[p]];
        s_mat_r[p]   <= odd_s[p] ? mat1_r[hidx_s[p]] : mat0_r[hidx_s[p]];
        s_d_r[p]     <= odd_s[p] ? d1_r[hidx_s[p]]   : d0_r[hidx_s[p]];
        s_v_r[p]     <= odd_s[p] ? v1_r[hidx_s[p]]   : v0_r[hidx_s[p]];
      end
    end
  end

  // INVTLB next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    latch_s     = 1'b0;
    clr_s       = 1'b0;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (inv_valid) begin
          latch_s = 1'b1;
          if (inv_op <= 5'd6) begin
            state_nxt_s = SCAN;
            ptr_nxt_s   = '0;
          end else begin
            done_nxt_s = 1'b1;
            err_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        clr_s = inv_hit(inv_op_r, g_r[ptr_r], asid_r[ptr_r], vppn_r[ptr_r], inv_asid_r, inv_vppn_r);
        if (ptr_r == IDXW'(TLBNUM - 1)) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = '0;
          done_nxt_s  = 1'b1;
        end else begin
          ptr_nxt_s = ptr_r + IDXW'(1);
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state, enable bits and fill pointer; the write is assigned last so it beats a scan clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;   ptr_r  <= '0;     fill_r <= '0;
      done_r  <= 1'b0;   err_r  <= 1'b0;   e_r    <= '0;
      inv_op_r <= 5'd0;  inv_asid_r <= 10'd0;  inv_vppn_r <= 19'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      done_r  <= done_nxt_s;
      err_r   <= err_nxt_s;
      if (latch_s) begin
        inv_op_r <= inv_op;  inv_asid_r <= inv_asid;  inv_vppn_r <= inv_vppn;
      end
      if (we && fill_ack) fill_r <= fill_r + IDXW'(1);
      if (clr_s) e_r[ptr_r] <= 1'b0;
      if (we) e_r[w_index] <= w_e;
    end
  end

  // Entry payload fields carry no reset; they are meaningless while e is clear.
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      vppn_r[w_index] <= w_vppn;    asid_r[w_index] <= w_asid;
      g_r[w_index]    <= w_g;       ps4m_r[w_index] <= (w_ps == 6'd22);
      ppn0_r[w_index] <= w_ppn0;    ppn1_r[w_index] <= w_ppn1;
      plv0_r[w_index] <= w_plv0;    plv1_r[w_index] <= w_plv1;
      mat0_r[w_index] <= w_mat0;    mat1_r[w_index] <= w_mat1;
      d0_r[w_index]   <= w_d0;      d1_r[w_index]   <= w_d1;
      v0_r[w_index]   <= w_v0;      v1_r[w_index]   <= w_v1;
    end
  end

  assign s0_found = s_found_r[0];  assign s0_index = s_index_r[0];  assign s0_ppn = s_ppn_r[0];
  assign s0_ps    = s_ps_r[0];     assign s0_plv   = s_plv_r[0];    assign s0_mat = s_mat_r[0];
  assign s0_d     = s_d_r[0];      assign s0_v     = s_v_r[0];
  assign s1_found = s_found_r[1];  assign s1_index = s_index_r[1];  assign s1_ppn = s_ppn_r[1];
  assign s1_ps    = s_ps_r[1];     assign s1_plv   = s_plv_r[1];    assign s1_mat = s_mat_r[1];
  assign s1_d     = s_d_r[1];      assign s1_v     = s_v_r[1];

  assign inv_busy   = (state_r == SCAN);
  assign inv_done   = done_r;
  assign inv_err    = err_r;
  assign fill_index = fill_r;

  assign r_e    = e_r[r_index];     assign r_vppn = vppn_r[r_index];  assign r_asid = asid_r[r_index];
  assign r_g    = g_r[r_index];     assign r_ps   = ps4m_r[r_index] ? 6'd22 : 6'd12;
  assign r_ppn0 = ppn0_r[r_index];  assign r_ppn1 = ppn1_r[r_index];
  assign r_plv0 = plv0_r[r_index];  assign r_plv1 = plv1_r[r_index];
  assign r_mat0 = mat0_r[r_index];  assign r_mat1 = mat1_r[r_index];
  assign r_d0   = d0_r[r_index];    assign r_d1   = d1_r[r_index];
  assign r_v0   = v0_r[r_index];    assign r_v1   = v1_r[r_index];

endmodule

// File: tb/tb_tlb_pipe.sv
// Scoreboard bench for tlb_pipe: search results queued at drive time, compared one cycle later.
module tb_tlb_pipe;
  localparam int N  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [18:0] s0_vppn, s1_vppn;  logic s0_va_bit12, s1_va_bit12;  logic [9:0] s0_asid, s1_asid;
  logic s0_found, s1_found;  logic [IW-1:0] s0_index, s1_index;  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0] s0_ps, s1_ps;  logic [1:0] s0_plv, s1_plv, s0_mat, s1_mat;
  logic s0_d, s1_d, s0_v, s1_v;
  logic inv_valid;  logic [4:0] inv_op;  logic [9:0] inv_asid;  logic [18:0] inv_vppn;
  logic inv_busy, inv_done, inv_err;
  logic we;  logic [IW-1:0] w_index;  logic w_e;  logic [18:0] w_vppn;  logic [5:0] w_ps;
  logic [9:0] w_asid;  logic w_g;  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0] w_plv0, w_plv1, w_mat0, w_mat1;  logic w_d0, w_d1, w_v0, w_v1;
  logic [IW-1:0] fill_index;  logic fill_ack;  logic [IW-1:0] r_index;
  logic r_e;  logic [18:0] r_vppn;  logic [5:0] r_ps;  logic [9:0] r_asid;  logic r_g;
  logic [19:0] r_ppn0, r_ppn1;  logic [1:0] r_plv0, r_plv1, r_mat0, r_mat1;
  logic r_d0, r_d1, r_v0, r_v1;

  tlb_pipe #(.TLBNUM(N)) dut (
    .clk(clk), .reset(reset),
    .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
    .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn), .s0_ps(s0_ps),
    .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
    .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn), .s1_ps(s1_ps),
    .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_busy(inv_busy), .inv_done(inv_done), .inv_err(inv_err),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps), .w_asid(w_asid),
    .w_g(w_g), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1), .w_plv0(w_plv0), .w_plv1(w_plv1),
    .w_mat0(w_mat0), .w_mat1(w_mat1), .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
    .fill_index(fill_index), .fill_ack(fill_ack), .r_index(r_index),
    .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1),
    .r_mat0(r_mat0), .r_mat1(r_mat1), .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1)
  );

  typedef struct {
    bit          port;
    logic        found;
    logic [3:0]  idx;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic        v;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int idx, input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                       input logic [9:0] asid, input logic g, input logic [19:0] p0, input logic [19:0] p1,
                       input logic v0, input logic v1);
    w_index = IW'(idx);  w_e = e;  w_vppn = vppn;  w_ps = ps;  w_asid = asid;  w_g = g;
    w_ppn0 = p0;  w_ppn1 = p1;  w_v0 = v0;  w_v1 = v1;
  endtask

  task automatic wr(input int idx, input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                    input logic [9:0] asid, input logic g, input logic [19:0] p0, input logic [19:0] p1,
                    input logic v0, input logic v1, input logic fill);
    set_w(idx, e, vppn, ps, asid, g, p0, p1, v0, v1);
    we = 1'b1;  fill_ack = fill;
    tick();
    we = 1'b0;  fill_ack = 1'b0;
  endtask

  task automatic srch_drive(input bit port, input logic [18:0] vppn, input logic b12, input logic [9:0] asid,
                            input logic found, input logic [3:0] idx, input logic [19:0] ppn,
                            input logic [5:0] ps, input logic v);
    exp_t x;
    if (port) begin s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid; end
    else      begin s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid; end
    x.port = port;  x.found = found;  x.idx = idx;  x.ppn = ppn;  x.ps = ps;  x.v = v;
    sb.push_back(x);
  endtask

  task automatic srch_check();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check_val(x.port ? "s1_found" : "s0_found", x.port ? s1_found : s0_found, x.found);
      check_val(x.port ? "s1_index" : "s0_index", x.port ? s1_index : s0_index, x.idx);
      check_val(x.port ? "s1_ppn"   : "s0_ppn",   x.port ? s1_ppn   : s0_ppn,   x.ppn);
      check_val(x.port ? "s1_ps"    : "s0_ps",    x.port ? s1_ps    : s0_ps,    x.ps);
      check_val(x.port ? "s1_v"     : "s0_v",     x.port ? s1_v     : s0_v,     x.v);
    end
  endtask

  task automatic srch(input bit port, input logic [18:0] vppn, input logic b12, input logic [9:0] asid,
                      input logic found, input logic [3:0] idx, input logic [19:0] ppn,
                      input logic [5:0] ps, input logic v);
    srch_drive(port, vppn, b12, asid, found, idx, ppn, ps, v);
    tick();
    srch_check();
  endtask

  task automatic chk_e(input string tag, input int idx, input logic exp);
    r_index = IW'(idx);
    #1;
    check_val(tag, r_e, exp);
  endtask

  initial begin
    int busy_n, done_n;
    logic any_e;
    reset = 1'b1;  inv_valid = 1'b0;  inv_op = 5'd0;  inv_asid = 10'd0;  inv_vppn = 19'd0;
    we = 1'b0;  fill_ack = 1'b0;  r_index = '0;
    set_w(0, 1'b0, 19'd0, 6'd12, 10'd0, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0);
    w_plv0 = 2'd0;  w_plv1 = 2'd0;  w_mat0 = 2'd0;  w_mat1 = 2'd0;  w_d0 = 1'b0;  w_d1 = 1'b0;
    s0_vppn = 19'd0;  s0_va_bit12 = 1'b0;  s0_asid = 10'd0;
    s1_vppn = 19'd0;  s1_va_bit12 = 1'b0;  s1_asid = 10'd0;
    tick();  tick();
    reset = 1'b0;
    check_val("rst_found", s0_found, 1'b0);
    check_val("rst_busy", inv_busy, 1'b0);
    check_val("rst_done", inv_done, 1'b0);
    check_val("rst_fill", fill_index, 4'd0);
    chk_e("rst_e0", 0, 1'b0);

    // basic 4KB hit, both halves, asid miss
    wr(3, 1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'hAAAAA, 20'h55555, 1'b1, 1'b0, 1'b0);
    check_val("fill_hold", fill_index, 4'd0);
    srch(1'b0, 19'h12345, 1'b0, 10'd5, 1'b1, 4'd3, 20'hAAAAA, 6'd12, 1'b1);
    srch(1'b0, 19'h12345, 1'b1, 10'd5, 1'b1, 4'd3, 20'h55555, 6'd12, 1'b0);
    srch(1'b1, 19'h12345, 1'b0, 10'd6, 1'b0, 4'd0, 20'd0, 6'd0, 1'b0);

    // a write is invisible to the search sampled at the same edge
    set_w(4, 1'b1, 19'h00777, 6'd12, 10'd5, 1'b0, 20'h33333, 20'h44444, 1'b1, 1'b1);
    we = 1'b1;
    srch_drive(1'b0, 19'h00777, 1'b0, 10'd5, 1'b0, 4'd0, 20'd0, 6'd0, 1'b0);
    tick();
    we = 1'b0;
    srch_check();
    srch(1'b0, 19'h00777, 1'b0, 10'd5, 1'b1, 4'd4, 20'h33333, 6'd12, 1'b1);

    // two 4MB hits: lowest index wins, odd page via vppn[9]
    wr(2, 1'b1, 19'h40200, 6'd22, 10'd1, 1'b0, 20'h00001, 20'h00011, 1'b0, 1'b1, 1'b0);
    wr(9, 1'b1, 19'h40200, 6'd22, 10'd1, 1'b0, 20'h00002, 20'h00022, 1'b0, 1'b1, 1'b0);
    srch(1'b1, 19'h40201, 1'b0, 10'd1, 1'b1, 4'd2, 20'h00011, 6'd22, 1'b1);
    srch(1'b0, 19'h40001, 1'b1, 10'd1, 1'b1, 4'd2, 20'h00001, 6'd22, 1'b0);
    r_index = 4'd9;  #1;
    check_val("rd_ppn1", r_ppn1, 20'h00022);
    check_val("rd_ps", r_ps, 6'd22);

    // fill index round-robin with wrap
    for (int k = 1; k <= 17; k++) begin
      wr(15, 1'b0, 19'd0, 6'd12, 10'd0, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0, 1'b1);
      check_val("fill", fill_index, 32'(k % N));
    end

    // INVTLB op4 asid7, with an inv_valid that must be ignored mid-scan
    wr(0, 1'b1, 19'h00100, 6'd12, 10'd3, 1'b1, 20'd0, 20'd0, 1'b1, 1'b1, 1'b0);
    wr(1, 1'b1, 19'h00200, 6'd12, 10'd7, 1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 1'b0);
    wr(2, 1'b1, 19'h00300, 6'd12, 10'd8, 1'b0, 20'd0, 20'd0, 1'b1, 1'b1, 1'b0);
    inv_op = 5'd4;  inv_asid = 10'd7;  inv_valid = 1'b1;
    tick();
    inv_valid = 1'b0;
    busy_n = 0;  done_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (inv_busy) busy_n++;
      if (inv_done) done_n++;
      inv_valid = (c == 5);
      inv_op = 5'd0;
      tick();
    end
    inv_valid = 1'b0;
    check_val("op4_busy_cycles", busy_n, 16);
    check_val("op4_done_pulses", done_n, 1);
    chk_e("op4_e0", 0, 1'b1);
    chk_e("op4_e1", 1, 1'b0);
    chk_e("op4_e2", 2, 1'b1);
    chk_e("op4_e3", 3, 1'b1);
    chk_e("op4_e9", 9, 1'b1);

    // illegal op
    inv_op = 5'd9;  inv_valid = 1'b1;
    tick();
    inv_valid = 1'b0;
    check_val("bad_done", inv_done, 1'b1);
    check_val("bad_err", inv_err, 1'b1);
    check_val("bad_busy", inv_busy, 1'b0);
    tick();
    check_val("bad_done_end", inv_done, 1'b0);
    check_val("bad_err_end", inv_err, 1'b0);
    check_val("bad_busy2", inv_busy, 1'b0);
    chk_e("bad_e0", 0, 1'b1);
    chk_e("bad_e2", 2, 1'b1);

    // op0 scan, write beats clear on entry 5, then reset aborts
    inv_op = 5'd0;  inv_valid = 1'b1;
    tick();
    inv_valid = 1'b0;
    repeat (5) tick();
    set_w(5, 1'b1, 19'h05555, 6'd12, 10'd2, 1'b0, 20'h0BEEF, 20'd0, 1'b1, 1'b0);
    we = 1'b1;
    tick();
    we = 1'b0;
    chk_e("op0_e4", 4, 1'b0);
    chk_e("op0_e5", 5, 1'b1);
    repeat (3) tick();
    check_val("op0_busy", inv_busy, 1'b1);
    reset = 1'b1;
    set_w(6, 1'b1, 19'h06666, 6'd12, 10'd2, 1'b0, 20'd0, 20'd0, 1'b1, 1'b0);
    we = 1'b1;
    tick();
    we = 1'b0;
    reset = 1'b0;
    check_val("rst2_busy", inv_busy, 1'b0);
    check_val("rst2_done", inv_done, 1'b0);
    check_val("rst2_fill", fill_index, 4'd0);
    any_e = 1'b0;
    for (int i = 0; i < N; i++) begin
      r_index = IW'(i);  #1;
      any_e = any_e | r_e;
    end
    check_val("rst2_any_e", any_e, 1'b0);
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (inv_done) done_n++;
      tick();
    end
    check_val("rst2_no_done", done_n, 0);
    srch(1'b0, 19'h05555, 1'b0, 10'd2, 1'b0, 4'd0, 20'd0, 6'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
